// File: rtl/esm_pkg.sv
// esm_pkg: shared defaults for the ESM front-end replay buffer.
//   ESM_IW / ESM_BS  default instruction width and buffer depth
//   esm_instr_t      instruction word at the default width
//   esm_ptr_width()  pointer width for a given depth: one extra bit above the
//                    slot index so that full and empty are distinguishable
package esm_pkg;

  localparam int ESM_IW = 16;
  localparam int ESM_BS = 16;

  typedef logic [ESM_IW-1:0] esm_instr_t;

  function automatic int esm_ptr_width(input int bs);
    return $clog2(bs) + 1;
  endfunction

endpackage

// File: rtl/esm_instr_mem.sv
// esm_instr_mem: BS x IW register array for the replay buffer.
//   clk    write clock (rising edge)
//   we     write enable
//   waddr  write slot
//   wdata  word to store
//   raddr  read slot
//   rdata  word at raddr, combinational read
// Contents are intentionally not reset.
module esm_instr_mem
  import esm_pkg::*;
#(
  parameter int IW = ESM_IW,
  parameter int BS = ESM_BS
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [$clog2(BS)-1:0] waddr,
  input  logic [IW-1:0]         wdata,
  input  logic [$clog2(BS)-1:0] raddr,
  output logic [IW-1:0]         rdata
);

  logic [IW-1:0] mem [BS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/esm_replay_buffer.sv
// esm_replay_buffer: in-order instruction buffer with commit/rewind replay.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_instr     enqueue handshake
//   out_valid/out_ready/out_instr  issue handshake, out_index = slot of out_instr
//   commit    retire everything issued before this edge
//   rewind    restart issue from the oldest retained instruction
//   flush     discard all contents
//   count     retained entries, pending = unissued entries
// Pointers carry one extra wrap bit; slots are the low bits.
module esm_replay_buffer
  import esm_pkg::*;
#(
  parameter int IW = ESM_IW,
  parameter int BS = ESM_BS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IW-1:0]         in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IW-1:0]         out_instr,
  output logic [$clog2(BS)-1:0] out_index,
  input  logic                  commit,
  input  logic                  rewind,
  input  logic                  flush,
  output logic [esm_ptr_width(BS)-1:0] count,
  output logic [esm_ptr_width(BS)-1:0] pending
);

  localparam int PW = esm_ptr_width(BS);
  localparam int AW = $clog2(BS);
  localparam logic [PW-1:0] FULL_CNT = PW'(BS);
  localparam logic [PW-1:0] ONE      = PW'(1);

  logic [PW-1:0] base_ptr, rd_ptr, wr_ptr;
  logic          enq, deq;

  assign count   = wr_ptr - base_ptr;
  assign pending = wr_ptr - rd_ptr;

  // Handshake readiness depends only on pointer state and control inputs,
  // never on in_valid/out_ready.
  assign in_ready  = !rst && !flush && (count != FULL_CNT);
  assign out_valid = !rst && !flush && !rewind && (rd_ptr != wr_ptr);

  assign enq = in_valid && in_ready;
  assign deq = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      base_ptr <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + ONE;
      if (rewind) begin
        rd_ptr <= base_ptr;
      end else begin
        if (deq)    rd_ptr   <= rd_ptr + ONE;
        // Pre-edge rd: an instruction dequeued this cycle stays retained.
        if (commit) base_ptr <= rd_ptr;
      end
    end
  end

  assign out_index = rd_ptr[AW-1:0];

  esm_instr_mem #(
    .IW (IW),
    .BS (BS)
  ) u_mem (
    .clk   (clk),
    .we    (enq),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_instr),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_instr)
  );

endmodule

// File: tb/tb_esm_replay_buffer.sv
module tb_esm_replay_buffer;

  localparam int IW = 16;
  localparam int BS = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [IW-1:0] in_instr;
  logic          out_valid, out_ready;
  logic [IW-1:0] out_instr;
  logic [3:0]    out_index;
  logic          commit, rewind, flush;
  logic [4:0]    count, pending;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: retained instructions in order, how many of them are issued,
  // and the absolute position of the oldest one (for slot numbers).
  logic [IW-1:0] q[$];
  int n_iss   = 0;
  int base_abs = 0;

  always #5 clk = ~clk;

  esm_replay_buffer #(.IW(IW), .BS(BS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_index (out_index),
    .commit    (commit),
    .rewind    (rewind),
    .flush     (flush),
    .count     (count),
    .pending   (pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in_ready();
    return !rst && !flush && (q.size() != BS);
  endfunction

  function automatic bit m_out_valid();
    return !rst && !flush && !rewind && (n_iss < q.size());
  endfunction

  always @(posedge clk) begin
    bit e, d;
    int nn;
    if (rst || flush) begin
      q.delete();
      n_iss    = 0;
      base_abs = 0;
    end else begin
      e = in_valid && m_in_ready();
      d = out_ready && m_out_valid();
      if (rewind) begin
        n_iss = 0;
      end else begin
        nn = commit ? 0 : n_iss;
        if (commit) begin
          repeat (n_iss) void'(q.pop_front());
          base_abs += n_iss;
        end
        n_iss = nn + (d ? 1 : 0);
      end
      if (e) q.push_back(in_instr);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_in_ready", in_ready, m_in_ready());
      check("m_out_valid", out_valid, m_out_valid());
      check("m_count", count, q.size());
      check("m_pending", pending, q.size() - n_iss);
      if (m_out_valid() && out_valid) begin
        check("m_out_instr", out_instr, q[n_iss]);
        check("m_out_index", out_index, (base_abs + n_iss) % BS);
      end
    end
  end

  task automatic drv(input logic iv, input logic [IW-1:0] ii, input logic ord,
                     input logic cm, input logic rw, input logic fl);
    in_valid  = iv;
    in_instr  = ii;
    out_ready = ord;
    commit    = cm;
    rewind    = rw;
    flush     = fl;
  endtask

  task automatic idle();
    drv(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_pending", pending, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_index", out_index, 0);

    drv(1, 16'h1111, 0, 0, 0, 0); tick();
    drv(1, 16'h2222, 0, 0, 0, 0); tick();
    idle();
    #1;
    check("two_pending", pending, 2);
    check("two_count", count, 2);
    check("two_out_instr", out_instr, 16'h1111);
    check("two_out_index", out_index, 0);
    drv(0, 16'h0, 0, 0, 0, 1); tick();

    for (int i = 0; i < 16; i++) begin
      drv(1, 16'h0100 + 16'(i), 1, 0, 0, 0); tick();
    end
    drv(0, 16'h0, 1, 0, 0, 0); tick(); tick();
    idle();
    #1;
    check("fill_pending", pending, 0);
    check("fill_count", count, 16);
    check("fill_in_ready", in_ready, 0);
    drv(0, 16'h0, 0, 1, 0, 0); tick();
    idle();
    #1;
    check("commit_count", count, 0);
    check("commit_in_ready", in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      drv(1, 16'h00A0 + 16'(i), 0, 0, 0, 0); tick();
    end
    drv(0, 16'h0, 1, 0, 0, 0); tick(); tick(); tick();
    drv(0, 16'h0, 1, 0, 1, 0);
    #1;
    check("rewind_out_valid", out_valid, 0);
    tick();
    idle();
    #1;
    check("rewind_out_instr", out_instr, 16'h00A0);
    check("rewind_pending", pending, 5);
    check("rewind_out_index", out_index, 0);

    drv(0, 16'h0, 1, 0, 0, 0); tick(); tick();
    drv(0, 16'h0, 0, 1, 0, 0); tick();
    drv(0, 16'h0, 1, 0, 0, 0); tick();
    drv(0, 16'h0, 0, 0, 1, 0); tick();
    idle();
    #1;
    check("replay_out_instr", out_instr, 16'h00A2);
    check("replay_count", count, 3);

    drv(0, 16'h0, 1, 1, 0, 0); tick();
    idle();
    #1;
    check("cmdq_count", count, 3);
    check("cmdq_pending", pending, 2);
    check("cmdq_out_instr", out_instr, 16'h00A3);
    drv(0, 16'h0, 1, 0, 0, 0); tick();
    drv(0, 16'h0, 0, 1, 1, 0); tick();
    idle();
    #1;
    check("rwcm_count", count, 3);
    check("rwcm_pending", pending, 3);
    check("rwcm_out_instr", out_instr, 16'h00A2);

    drv(1, 16'h00B0, 0, 0, 0, 0); tick();
    drv(1, 16'h00B1, 0, 0, 0, 0); tick();
    idle();
    #1;
    check("pre_flush_count", count, 5);
    drv(1, 16'hDEAD, 1, 1, 1, 1); tick();
    idle();
    #1;
    check("flush_count", count, 0);
    check("flush_pending", pending, 0);
    check("flush_out_valid", out_valid, 0);
    drv(1, 16'h00C0, 0, 0, 0, 0); tick();
    idle();
    #1;
    check("post_flush_instr", out_instr, 16'h00C0);
    check("post_flush_index", out_index, 0);
    check("post_flush_count", count, 1);

    for (int i = 0; i < 40; i++) begin
      drv(1, 16'hE000 + 16'(i), 1, 1, 0, 0); tick();
    end
    drv(0, 16'h0, 1, 1, 0, 0); tick(); tick(); tick();
    idle();
    #1;
    check("wrap_count", count, 0);
    check("wrap_pending", pending, 0);
    check("wrap_out_index", out_index, 41 % BS);

    drv(1, 16'h5555, 0, 0, 0, 0); tick(); tick();
    idle();
    rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);

    tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
